hazard_ctrl: RTL and testbench



---
 rtl/core_ctrl_pkg.sv | 24 ++
 rtl/div_latency_counter.sv | 36 +++
 rtl/hazard_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the pipeline control block: controller state encoding
// and the RV32M divide encodings that upstream decode uses to form exe_is_div.
package core_ctrl_pkg;

    typedef enum logic {
        RUN = 1'b0,
        DIV = 1'b1
    } ctrl_state_e;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [2:0] F3_DIV        = 3'b100;
    localparam logic [2:0] F3_DIVU       = 3'b101;
    localparam logic [2:0] F3_REM        = 3'b110;
    localparam logic [2:0] F3_REMU       = 3'b111;

    // DIV/DIVU/REM/REMU all share funct3[2]=1 within the M-extension space
    function automatic logic is_div_op(input logic [6:0] opcode,
                                       input logic [6:0] funct7,
                                       input logic [2:0] funct3);
        return (opcode == OPC_OP) && (funct7 == FUNCT7_MULDIV) && funct3[2];
    endfunction

endpackage

// File: rtl/div_latency_counter.sv
// Loadable down-counter that sequences a multi-cycle divide; zero marks the
// divide's final (result-valid) cycle.
module div_latency_counter #(
    parameter int DIV_LATENCY = 4,
    parameter int CW          = $clog2(DIV_LATENCY + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    // Start value leaves one trailing zero-count cycle for the done cycle
    localparam logic [CW-1:0] LOAD_VAL = CW'((DIV_LATENCY >= 2) ? (DIV_LATENCY - 2) : 0);

    logic [CW-1:0] cnt_r;

    // Count register: reset, load on divide start, decrement while busy
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (dec && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt  = cnt_r;
    assign zero = (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: load-use hazards, taken
// jumps, multi-cycle divide sequencing and a stall-cycle performance counter.
module hazard_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int DIV_LATENCY = 4,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hzd_exe_to_id_A,
    input  logic             hzd_mem_to_exe_A,
    input  logic             hzd_mem_to_exe_B,
    input  logic             id_jump_taken,
    input  logic             exe_is_div,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_exe,
    output logic             flush_id,
    output logic             flush_exe,
    output logic             flush_mem,
    output logic             div_start,
    output logic             div_done,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int   DCW   = $clog2(DIV_LATENCY + 1);
    localparam logic MULTI = (DIV_LATENCY >= 2) ? 1'b1 : 1'b0;

    ctrl_state_e     state_r;
    logic [DCW-1:0]  div_cnt_s;
    logic            cnt_zero_s;
    logic            in_run_s;
    logic            mem_hzd_s;
    logic            exe_stall_s;
    logic            cnt_load_s;
    logic            cnt_dec_s;
    logic [CNT_W-1:0] stall_cnt_r;

    div_latency_counter #(
        .DIV_LATENCY (DIV_LATENCY),
        .CW          (DCW)
    ) u_div_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load_s),
        .dec  (cnt_dec_s),
        .cnt  (div_cnt_s),
        .zero (cnt_zero_s)
    );

    // Mealy output decode; priority is reset, EXE hold, EXE->ID hazard, jump
    always_comb begin
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_exe   = 1'b0;
        flush_id    = 1'b0;
        flush_exe   = 1'b0;
        flush_mem   = 1'b0;
        div_start   = 1'b0;
        div_done    = 1'b0;
        div_busy    = 1'b0;
        exe_stall_s = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        in_run_s    = (state_r == RUN);
        mem_hzd_s   = hzd_mem_to_exe_A | hzd_mem_to_exe_B;
        if (rst) begin
            flush_id  = 1'b1;
            flush_exe = 1'b1;
            flush_mem = 1'b1;
        end else begin
            // Operands must be forwarded before the divider may latch them
            div_start   = in_run_s & exe_is_div & ~mem_hzd_s;
            exe_stall_s = mem_hzd_s | (in_run_s & exe_is_div & MULTI) | (~in_run_s & ~cnt_zero_s);
            div_done    = (~in_run_s & cnt_zero_s) | (~MULTI & div_start);
            div_busy    = ~in_run_s;
            cnt_load_s  = div_start & MULTI;
            cnt_dec_s   = ~in_run_s & ~cnt_zero_s;
            if (exe_stall_s) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                stall_exe = 1'b1;
                flush_mem = 1'b1;
            end else if (hzd_exe_to_id_A) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                flush_exe = 1'b1;
            end else begin
                flush_id = id_jump_taken;
            end
        end
    end

    // Controller state; the done cycle returns to RUN so the same divide
    // still sitting in EXE is not started twice
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            case (state_r)
                RUN: state_r <= (div_start && MULTI) ? DIV : RUN;
                DIV: state_r <= cnt_zero_s ? RUN : DIV;
                default: state_r <= RUN;
            endcase
        end
    end

    // Free-running stall-cycle counter, wraps modulo 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_if) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised bench for hazard_ctrl: a 4-cycle-divide instance and a
// single-cycle-divide instance checked against a cycle-age reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, hzd_ei, hzd_ma, hzd_mb, jmp, dv;

    logic       s_if4, s_id4, s_ex4, f_id4, f_ex4, f_mem4, st4, dn4, bz4;
    logic [3:0] cnt4_o;
    logic       s_if1, s_id1, s_ex1, f_id1, f_ex1, f_mem1, st1, dn1, bz1;
    logic [7:0] cnt1_o;

    hazard_ctrl #(.DIV_LATENCY(4), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .hzd_exe_to_id_A(hzd_ei), .hzd_mem_to_exe_A(hzd_ma),
        .hzd_mem_to_exe_B(hzd_mb), .id_jump_taken(jmp), .exe_is_div(dv),
        .stall_if(s_if4), .stall_id(s_id4), .stall_exe(s_ex4), .flush_id(f_id4),
        .flush_exe(f_ex4), .flush_mem(f_mem4), .div_start(st4), .div_done(dn4),
        .div_busy(bz4), .stall_cnt(cnt4_o)
    );

    hazard_ctrl #(.DIV_LATENCY(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .hzd_exe_to_id_A(hzd_ei), .hzd_mem_to_exe_A(hzd_ma),
        .hzd_mem_to_exe_B(hzd_mb), .id_jump_taken(jmp), .exe_is_div(dv),
        .stall_if(s_if1), .stall_id(s_id1), .stall_exe(s_ex1), .flush_id(f_id1),
        .flush_exe(f_ex1), .flush_mem(f_mem1), .div_start(st1), .div_done(dn1),
        .div_busy(bz1), .stall_cnt(cnt1_o)
    );

    int n_vec = 0;
    int n_bad = 0;
    int age4 = -1;
    int age1 = -1;
    int exp_cnt4 = 0;
    int exp_cnt1 = 0;
    bit cnt_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // age: -1 when no divide is in flight, else cycles elapsed since div_start.
    // Bits: {stall_if, stall_id, stall_exe, flush_id, flush_exe, flush_mem,
    //        div_start, div_done, div_busy}
    function automatic logic [8:0] model_out(input int lat, input int age, input logic r,
                                             input logic ei, input logic ma, input logic mb,
                                             input logic j, input logic d);
        logic [8:0] o;
        logic start, hold;
        o = 9'd0;
        if (r) begin
            o[5] = 1'b1; o[4] = 1'b1; o[3] = 1'b1;
        end else begin
            start = (age < 0) && d && !ma && !mb;
            hold  = ma || mb || ((age < 0) && d && lat >= 2) || (age >= 1 && age < lat - 1);
            o[2]  = start;
            o[1]  = (age >= 1 && age == lat - 1) || (lat == 1 && start);
            o[0]  = (age >= 1);
            if (hold) begin
                o[8] = 1'b1; o[7] = 1'b1; o[6] = 1'b1; o[3] = 1'b1;
            end else if (ei) begin
                o[8] = 1'b1; o[7] = 1'b1; o[4] = 1'b1;
            end else begin
                o[5] = j;
            end
        end
        return o;
    endfunction

    function automatic int model_next_age(input int lat, input int age, input logic r,
                                          input logic ma, input logic mb, input logic d);
        if (r) return -1;
        if (age < 0) return (d && !ma && !mb && lat >= 2) ? 1 : -1;
        if (age >= lat - 1) return -1;
        return age + 1;
    endfunction

    task automatic step(input logic r, input logic ei, input logic ma, input logic mb,
                        input logic j, input logic d);
        logic [8:0] e4, e1;
        @(negedge clk);
        rst = r; hzd_ei = ei; hzd_ma = ma; hzd_mb = mb; jmp = j; dv = d;
        #1;
        e4 = model_out(4, age4, r, ei, ma, mb, j, d);
        e1 = model_out(1, age1, r, ei, ma, mb, j, d);
        check_eq("outs_lat4", {23'd0, s_if4, s_id4, s_ex4, f_id4, f_ex4, f_mem4, st4, dn4, bz4},
                 {23'd0, e4});
        check_eq("outs_lat1", {23'd0, s_if1, s_id1, s_ex1, f_id1, f_ex1, f_mem1, st1, dn1, bz1},
                 {23'd0, e1});
        if (cnt_known) begin
            check_eq("stall_cnt_lat4", {28'd0, cnt4_o}, 32'(exp_cnt4));
            check_eq("stall_cnt_lat1", {24'd0, cnt1_o}, 32'(exp_cnt1));
        end
        if (r) begin
            exp_cnt4 = 0; exp_cnt1 = 0; cnt_known = 1'b1;
        end else begin
            exp_cnt4 = (exp_cnt4 + int'(e4[8])) % 16;
            exp_cnt1 = (exp_cnt1 + int'(e1[8])) % 256;
        end
        age4 = model_next_age(4, age4, r, ma, mb, d);
        age1 = model_next_age(1, age1, r, ma, mb, d);
    endtask

    initial begin
        rst = 1'b1; hzd_ei = 1'b0; hzd_ma = 1'b0; hzd_mb = 1'b0; jmp = 1'b0; dv = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        // Jump alone, then jump masked by an EXE->ID hazard
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Single MEM->EXE hazard on operand B, then both hazard kinds together
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        // Divide held through its done cycle, then released
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Divide blocked by an operand hazard, starting once it clears
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset in the second cycle of a divide aborts it
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Enough stall cycles to wrap the 4-bit counter
        for (int i = 0; i < 18; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
